cdma_rx_scheduler: RTL and testbench
====================================

Name: cdma_rx_scheduler

Overview:
- Time-shares the single CDMA despreading receiver between its two user codes.
- Arbitrates user demodulation requests round-robin and drives the receiver's user select and reset, so its LFSR and chip counter realign on every switch.
- Dwells on the granted user for a fixed number of symbols, samples the receiver's bit/valid at each symbol boundary, and queues tagged bits into a 4-entry output FIFO with a valid/ready handshake.
- Sits between the receiver and the downstream packet/CPU interface.

Parameters:
- CHIPS_PER_SYM, 64, chips per symbol; must equal the receiver's correlation period.
- SYMS_PER_SLOT, 4, symbols dwelt per grant (1..255).
- MISS_LIMIT, 3, consecutive symbols without rx_valid before lock is declared lost (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-user demodulation request; bit0 = user 1, bit1 = user 2
- rx_data  in  1  receiver data_out
- rx_valid  in  1  receiver data_valid
- rx_rst  out  1  receiver reset, active-high, registered
- user_select  out  1  receiver user select (0 = code 1, 1 = code 2), registered
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_data  out  1  FIFO head bit
- out_user  out  1  FIFO head user tag
- lock_lost  out  2  sticky per-user lock-loss flag
- overflow  out  1  sticky FIFO overflow flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; rx_rst=1; user_select=0; out_valid=0; out_data=0; out_user=0; lock_lost=0; overflow=0; busy=0; FIFO empty; last_grant=1, so user 1 wins the first tie.
- States: IDLE, ARB, CLEAR, DWELL, DRAIN.
- IDLE: rx_rst=1. If req!=0, go to ARB on the next cycle.
- ARB (1 cycle): both req bits set → grant the user opposite last_grant. One bit set → grant that user. None → IDLE. On a grant: set user_select and last_grant, clear lock_lost[granted], go to CLEAR.
- CLEAR (1 cycle): rx_rst=1. Clear chip_cnt, sym_cnt and miss_cnt. Go to DWELL; rx_rst=0 from the first DWELL cycle.
- DWELL: chip_cnt counts 0..CHIPS_PER_SYM-1 and wraps. The first DWELL cycle is chip 0, matching the receiver's chip_count.
- Symbol end: chip_cnt==CHIPS_PER_SYM-1. Increment sym_cnt and set sample_pend. The sample occurs on the following cycle, because the receiver's data_valid is registered one cycle after its chip 63.
- Sample cycle, rx_valid=1: push {user_select, rx_data} into the FIFO and clear miss_cnt.
- Sample cycle, rx_valid=0: increment miss_cnt (saturating). When it reaches MISS_LIMIT, set lock_lost[user] and end the slot early.
- Slot end (symbol end with sym_cnt reaching SYMS_PER_SLOT, or req[user] low at a symbol end) → DRAIN. DRAIN performs the pending sample, then goes to ARB. A lock-loss early end goes from the sample cycle to ARB.
- req[user] deasserting mid-symbol has no effect until the symbol end.
- Slot length: 1 (CLEAR) + SYMS_PER_SLOT*CHIPS_PER_SYM + 1 (DRAIN) + 1 (ARB) cycles; defaults give 259.
- FIFO: 4 entries, 2-bit pointers plus a 3-bit count.
  - Head is presented combinationally on out_valid/out_data/out_user.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full without a pop: drop the entry and set overflow.
- Sticky flags clear only by reset, except lock_lost[u], which also clears on a grant to user u.
- Reset asserted mid-slot returns to IDLE immediately with rx_rst=1. No partial symbol is pushed.

Test Plan:
- req=2'b01, receiver model returns bits 1,0,1,1 each with valid → 4 FIFO entries, user 0, data 1,0,1,1. rx_rst high for exactly 1 cycle before the first chip. Returns to ARB after 259 cycles.
- req=2'b11 held for 3 slots → grants user 0, 1, 0. user_select toggles only in ARB. rx_rst pulses once per slot.
- rx_valid never asserted with MISS_LIMIT=3 → lock_lost[0]=1 after the 3rd symbol's sample cycle. Slot ends early (no 4th symbol). Flag clears on the next grant to user 0.
- out_ready=0 through 2 slots (8 valid bits) → first 4 bits retained in order, overflow=1. Then out_ready=1 → exactly 4 pops.
- FIFO full, out_ready=1 on a sample cycle → simultaneous push and pop. Count stays 4, overflow stays 0.
- rst_n pulsed low at chip 30 of symbol 2 → all outputs at reset values asynchronously, FIFO empty, rx_rst=1. The next request starts from ARB with user 0.

Source files
------------

// File: rtl/cdma_rx_scheduler.sv
// cdma_rx_scheduler: time-shares one CDMA despreading receiver between two
// user codes. It grants users round-robin, resets the receiver on every
// switch, dwells a fixed number of symbols and queues tagged bits in a
// 4-entry FIFO.
module cdma_rx_scheduler #(
    parameter int CHIPS_PER_SYM = 64,
    parameter int SYMS_PER_SLOT = 4,
    parameter int MISS_LIMIT    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       rx_data,
    input  logic       rx_valid,
    output logic       rx_rst,
    output logic       user_select,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic       out_user,
    output logic [1:0] lock_lost,
    output logic       overflow,
    output logic       busy
);

    localparam int            CW        = (CHIPS_PER_SYM > 1) ? $clog2(CHIPS_PER_SYM) : 1;
    localparam logic [CW-1:0] CHIP_LAST = CW'(CHIPS_PER_SYM - 1);
    localparam logic [7:0]    SYM_LAST  = 8'(SYMS_PER_SLOT);
    localparam logic [3:0]    MISS_LIM  = 4'(MISS_LIMIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_DWELL = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] chip_q, chip_d;
    logic [7:0]    sym_q, sym_d;
    logic [3:0]    miss_q, miss_d;
    logic          pend_q, pend_d;
    logic          last_grant_q, last_grant_d;
    logic          user_sel_q, user_sel_d;
    logic          rx_rst_q, rx_rst_d;
    logic [1:0]    lock_lost_q, lock_lost_d;
    logic          grant_u;
    logic          push;

    logic [3:0][1:0] fifo_q;
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic            pop, do_push;

    // Scheduler next state: arbitration, chip/symbol counting, sampling.
    always_comb begin
        state_d      = state_q;
        chip_d       = chip_q;
        sym_d        = sym_q;
        miss_d       = miss_q;
        pend_d       = pend_q;
        last_grant_d = last_grant_q;
        user_sel_d   = user_sel_q;
        lock_lost_d  = lock_lost_q;
        push         = 1'b0;
        // On a tie the user that did not win last time gets the grant.
        grant_u      = (req == 2'b11) ? ~last_grant_q : req[1];

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) state_d = S_ARB;
            end
            S_ARB: begin
                if (req != 2'b00) begin
                    user_sel_d           = grant_u;
                    last_grant_d         = grant_u;
                    lock_lost_d[grant_u] = 1'b0;
                    state_d              = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                chip_d  = '0;
                sym_d   = '0;
                miss_d  = '0;
                pend_d  = 1'b0;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                pend_d = 1'b0;
                if (chip_q == CHIP_LAST) begin
                    chip_d = '0;
                    sym_d  = sym_q + 8'd1;
                    pend_d = 1'b1;
                    // Request drop is only honoured at a symbol boundary.
                    if ((sym_q + 8'd1 == SYM_LAST) || !req[user_sel_q]) state_d = S_DRAIN;
                end else begin
                    chip_d = chip_q + 1'b1;
                end
            end
            S_DRAIN: begin
                pend_d  = 1'b0;
                state_d = S_ARB;
            end
            default: state_d = S_IDLE;
        endcase

        // Receiver data_valid lags its last chip by one cycle, so the sample
        // lands on the cycle after the symbol end (next DWELL chip or DRAIN).
        if (pend_q && (state_q == S_DWELL || state_q == S_DRAIN)) begin
            if (rx_valid) begin
                push   = 1'b1;
                miss_d = '0;
            end else begin
                if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
                if (miss_d >= MISS_LIM) begin
                    lock_lost_d[user_sel_q] = 1'b1;
                    if (state_q == S_DWELL) state_d = S_ARB;
                end
            end
        end

        rx_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    end

    // Scheduler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            chip_q       <= '0;
            sym_q        <= '0;
            miss_q       <= '0;
            pend_q       <= 1'b0;
            last_grant_q <= 1'b1;
            user_sel_q   <= 1'b0;
            rx_rst_q     <= 1'b1;
            lock_lost_q  <= '0;
        end else begin
            state_q      <= state_d;
            chip_q       <= chip_d;
            sym_q        <= sym_d;
            miss_q       <= miss_d;
            pend_q       <= pend_d;
            last_grant_q <= last_grant_d;
            user_sel_q   <= user_sel_d;
            rx_rst_q     <= rx_rst_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    // FIFO control: a pop frees a slot for a same-cycle push even when full.
    always_comb begin
        pop        = out_valid && out_ready;
        do_push    = push && ((cnt_q != 3'd4) || pop);
        overflow_d = overflow_q | (push && (cnt_q == 3'd4) && !pop);
        cnt_d      = cnt_q + {2'b00, do_push} - {2'b00, pop};
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= {user_sel_q, rx_data};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign rx_rst      = rx_rst_q;
    assign user_select = user_sel_q;
    assign out_valid   = (cnt_q != 3'd0);
    assign out_data    = fifo_q[rd_ptr_q][0];
    assign out_user    = fifo_q[rd_ptr_q][1];
    assign lock_lost   = lock_lost_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cdma_rx_scheduler.sv
// Bench for cdma_rx_scheduler: a chip-level receiver model feeds the DUT,
// and a slot-level reference (grant order, FIFO queue, miss runs, slot
// lengths) predicts every observable output.
module tb_cdma_rx_scheduler;

    localparam int CPS = 64;
    localparam int SPS = 4;
    localparam int ML  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = 2'b00;
    logic       rx_data = 1'b0;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       rx_rst, user_select, out_valid, out_data, out_user, overflow, busy;
    logic [1:0] lock_lost;

    cdma_rx_scheduler #(.CHIPS_PER_SYM(CPS), .SYMS_PER_SLOT(SPS), .MISS_LIMIT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_rst(rx_rst), .user_select(user_select), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_user(out_user),
        .lock_lost(lock_lost), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference state
    logic [1:0] q[$];
    bit         exp_ovf = 0;
    bit [1:0]   exp_ll = 0;
    bit         last_g = 1;
    bit         g = 0;
    bit         have_prev = 0;
    bit         req_touched = 0;
    bit         mon_en = 0;
    int         slot_cyc = 0;
    int         miss_run = 0;
    int         pulses = 0;
    int         ll_k = 0;
    int         vprob = 100;
    int         rmode = 1;          // 0 ready low, 1 high, 2 random, 3 only on sample cycles
    bit         prev_rst = 1;
    int         prev_chip = 0;
    bit         vn;
    int         chip;
    int         exp_len;

    // Receiver model + reference model, evaluated once per cycle at negedge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            // receiver: data_valid one cycle after chip CPS-1
            vn   = !prev_rst && (prev_chip == CPS - 1);
            chip = prev_rst ? 0 : (prev_chip + 1) % CPS;
            rx_valid = vn && ($urandom_range(99) < vprob);
            rx_data  = 1'($urandom_range(1));
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = 1'($urandom_range(1));
                default: out_ready = vn;
            endcase

            slot_cyc++;
            if (rx_rst && !prev_rst && busy) begin
                // receiver reset pulse inside a slot: this is the CLEAR cycle
                if (have_prev && !req_touched) begin
                    exp_len = (ll_k > 0 && ll_k < SPS) ? CPS * ll_k + 3 : 1 + SPS * CPS + 2;
                    chk("slot_len", slot_cyc, exp_len);
                end
                g = (req == 2'b11) ? ~last_g : req[1];
                last_g = g;
                exp_ll[g] = 1'b0;
                chk("grant", user_select, g);
                have_prev = 1; req_touched = 0; slot_cyc = 0;
                miss_run = 0; pulses = 0; ll_k = 0;
            end else if (rx_rst && !prev_rst) begin
                have_prev = 0;   // back to idle; next slot has no predecessor
            end
            if (have_prev && slot_cyc == 1) chk("rx_rst_len", rx_rst, 0);

            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0][0]);
                chk("out_user", out_user, q[0][1]);
            end
            chk("overflow", overflow, exp_ovf);
            chk("lock_lost", lock_lost, exp_ll);

            // end-of-cycle effects
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (vn) begin
                pulses++;
                if (rx_valid) begin
                    miss_run = 0;
                    if (q.size() < 4) q.push_back({g, rx_data});
                    else exp_ovf = 1;
                end else begin
                    miss_run++;
                    if (miss_run >= ML) begin
                        exp_ll[g] = 1'b1;
                        if (ll_k == 0) ll_k = pulses;
                    end
                end
            end
            prev_rst  = rx_rst;
            prev_chip = chip;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] v);
        @(negedge clk);
        #2;
        req = v;
        req_touched = 1;
    endtask

    // Caller sits just after a negedge; reset is asserted mid-cycle.
    task automatic do_reset();
        #1;
        rst_n = 1'b0; mon_en = 0; req = 2'b00; rx_valid = 1'b0;
        #1;
        chk("rst_rx_rst", rx_rst, 1);
        chk("rst_user_select", user_select, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_user", out_user, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        q.delete();
        exp_ovf = 0; exp_ll = 0; last_g = 1; have_prev = 0;
        prev_rst = 1; prev_chip = 0; slot_cyc = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1;
    endtask

    initial begin
        int t;
        @(negedge clk);
        do_reset();

        // single user, all bits valid
        rmode = 1; vprob = 100;
        set_req(2'b01);
        cyc(2 * 259 + 20);

        // both users requesting: alternating grants
        set_req(2'b11);
        cyc(3 * 259 + 10);

        // no valid ever: lock loss and early slot end
        vprob = 0;
        set_req(2'b01);
        cyc(3 * 200);
        set_req(2'b11);
        cyc(3 * 200);

        // downstream stalled for two slots, then drained
        @(negedge clk);
        do_reset();
        vprob = 100; rmode = 0;
        set_req(2'b01);
        cyc(2 * 259 + 5);
        rmode = 1;
        set_req(2'b00);
        cyc(400);
        chk("idle_busy", busy, 0);
        chk("idle_rx_rst", rx_rst, 1);

        // full FIFO with pop on the sample cycle
        @(negedge clk);
        do_reset();
        rmode = 0;
        set_req(2'b01);
        cyc(259 + 5);
        rmode = 3;
        cyc(2 * 259);

        // randomized traffic
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(2))
                0:       vprob = 100;
                1:       vprob = 80;
                default: vprob = 40;
            endcase
            rmode = $urandom_range(2);
            set_req(2'($urandom_range(3)));
            cyc($urandom_range(400, 100));
        end

        // reset in the middle of the second symbol
        @(negedge clk);
        do_reset();
        rmode = 0; vprob = 100;
        set_req(2'b11);
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(have_prev && slot_cyc == 1 + CPS + 30) && t < 2000);
        chk("mid_wait", t < 2000, 1);
        do_reset();
        rmode = 1;
        set_req(2'b11);
        cyc(300);
        set_req(2'b00);
        cyc(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
